// File: rtl/store_buffer_if.sv
// Store buffer port bundle: MEM-stage store handshake, load forwarding,
// data-memory write port and fence/halt drain request.
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          dm_busy;
    logic          dm_str;
    logic          dm_sel;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_D;
    logic          sync_req;
    logic          sync_done;
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_addr, st_data, ld_addr, dm_busy, sync_req,
        input  st_ready, ld_hit, ld_data, dm_str, dm_sel, dm_addr, dm_D,
        input  sync_done, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_addr, dm_busy, sync_req,
        output st_ready, ld_hit, ld_data, dm_str, dm_sel, dm_addr, dm_D,
        output sync_done, count
    );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer between MEM and data memory, with youngest-match
// load forwarding and a fence/halt drain sequencer.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input logic          clk,
    input logic          clr_n,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t        state;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic          full;
    logic          empty;
    logic          ready;
    logic          push;
    logic          pop;
    logic          hit;
    logic [DW-1:0] fwd;
    logic [PW-1:0] idx;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign ready = !full && (state != DRAIN);
    assign push  = bus.st_valid && ready;
    // Uses the pre-edge count, so a store never drains in its push cycle.
    assign pop   = !empty && !bus.dm_busy;

    assign bus.st_ready  = ready;
    assign bus.dm_str    = pop;
    assign bus.dm_sel    = pop;
    assign bus.dm_addr   = addr_q[head];
    assign bus.dm_D      = data_q[head];
    assign bus.ld_hit    = hit;
    assign bus.ld_data   = fwd;
    assign bus.sync_done = (state == DONE);
    assign bus.count     = cnt;

    // Walk oldest to youngest so the last match is the youngest one.
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < cnt && addr_q[idx] == bus.ld_addr) begin
                hit = 1'b1;
                fwd = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= bus.st_addr;
            data_q[tail] <= bus.st_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            state <= IDLE;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
            unique case (state)
                IDLE:    if (bus.sync_req) state <= DRAIN;
                DRAIN:   if (empty || (cnt == CW'(1) && pop)) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed vector table plus randomized run against a queue-based
// reference model of the store buffer.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 6;
    localparam int DW    = 32;

    typedef struct {
        logic          rn;
        logic          v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [AW-1:0] la;
        logic          busy;
        logic          sreq;
        logic          chk;
        logic          e_ready;
        logic          e_str;
        logic [AW-1:0] e_daddr;
        logic [DW-1:0] e_dd;
        logic          e_hit;
        logic [DW-1:0] e_ld;
        logic          e_done;
        int            e_cnt;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    vec_t tbl[$];
    ent_t q[$];
    int   phase = 0;

    store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            passed++;
    endtask

    task automatic drive(input logic rn, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [AW-1:0] la,
                         input logic busy, input logic sreq);
        clr_n        = rn;
        bus.st_valid = v;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.ld_addr  = la;
        bus.dm_busy  = busy;
        bus.sync_req = sreq;
    endtask

    task automatic add(input logic rn, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] la,
                       input logic busy, input logic sreq, input logic c,
                       input logic er, input logic es, input logic [31:0] eda,
                       input logic [31:0] edd, input logic eh,
                       input logic [31:0] eld, input logic edn, input int ec);
        vec_t r;
        r.rn = rn; r.v = v; r.a = a[AW-1:0]; r.d = d; r.la = la[AW-1:0];
        r.busy = busy; r.sreq = sreq; r.chk = c;
        r.e_ready = er; r.e_str = es; r.e_daddr = eda[AW-1:0]; r.e_dd = edd;
        r.e_hit = eh; r.e_ld = eld; r.e_done = edn; r.e_cnt = ec;
        tbl.push_back(r);
    endtask

    task automatic apply_vec(input vec_t r, input int n);
        drive(r.rn, r.v, r.a, r.d, r.la, r.busy, r.sreq);
        #2;
        if (r.chk) begin
            chk($sformatf("v%0d st_ready", n), bus.st_ready, r.e_ready);
            chk($sformatf("v%0d dm_str", n), bus.dm_str, r.e_str);
            chk($sformatf("v%0d dm_sel", n), bus.dm_sel, r.e_str);
            chk($sformatf("v%0d ld_hit", n), bus.ld_hit, r.e_hit);
            chk($sformatf("v%0d ld_data", n), bus.ld_data, r.e_ld);
            chk($sformatf("v%0d sync_done", n), bus.sync_done, r.e_done);
            chk($sformatf("v%0d count", n), bus.count, r.e_cnt);
            if (r.e_str) begin
                chk($sformatf("v%0d dm_addr", n), bus.dm_addr, r.e_daddr);
                chk($sformatf("v%0d dm_D", n), bus.dm_D, r.e_dd);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One cycle against the queue model: check outputs, then advance it.
    task automatic mstep(input string tag, input logic rn, input logic v,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [AW-1:0] la, input logic busy,
                         input logic sreq);
        int n;
        logic e_ready, e_pop, e_hit;
        logic [DW-1:0] e_ld;
        ent_t e;
        drive(rn, v, a, d, la, busy, sreq);
        #2;
        n = q.size();
        e_ready = (n < DEPTH) && (phase != 1);
        e_pop = (n > 0) && !busy;
        e_hit = 1'b0;
        e_ld = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!e_hit && q[i].a == la) begin
                e_hit = 1'b1;
                e_ld = q[i].d;
            end
        end
        chk({tag, " st_ready"}, bus.st_ready, e_ready);
        chk({tag, " dm_str"}, bus.dm_str, e_pop);
        chk({tag, " dm_sel"}, bus.dm_sel, e_pop);
        chk({tag, " ld_hit"}, bus.ld_hit, e_hit);
        chk({tag, " ld_data"}, bus.ld_data, e_ld);
        chk({tag, " sync_done"}, bus.sync_done, phase == 2);
        chk({tag, " count"}, bus.count, n);
        if (e_pop) begin
            chk({tag, " dm_addr"}, bus.dm_addr, q[0].a);
            chk({tag, " dm_D"}, bus.dm_D, q[0].d);
        end
        @(posedge clk);
        #1;
        if (!rn) begin
            q.delete();
            phase = 0;
        end else begin
            if (e_pop) void'(q.pop_front());
            if (v && e_ready) begin
                e.a = a;
                e.d = d;
                q.push_back(e);
            end
            case (phase)
                0: if (sreq) phase = 1;
                1: if (n == 0 || (n == 1 && e_pop)) phase = 2;
                default: phase = 0;
            endcase
        end
    endtask

    initial begin
        drive(0, 0, '0, '0, '0, 0, 0);
        // rn v a d la busy sreq chk | ready str daddr dD hit ld done cnt
        add(0,0, 0,0,          0, 0,0,0, 0,0,0,0,          0,0,          0,0);
        add(1,1, 5,'hAAAA0001, 5, 0,0,1, 1,0,0,0,          0,0,          0,0);
        add(1,0, 0,0,          5, 0,0,1, 1,1,5,'hAAAA0001, 1,'hAAAA0001, 0,1);
        add(1,0, 0,0,          5, 0,0,1, 1,0,0,0,          0,0,          0,0);
        add(1,1, 1,'h101,      0, 1,0,1, 1,0,0,0,          0,0,          0,0);
        add(1,1, 2,'h102,      0, 1,0,1, 1,0,0,0,          0,0,          0,1);
        add(1,1, 3,'h103,      0, 1,0,1, 1,0,0,0,          0,0,          0,2);
        add(1,1, 4,'h104,      0, 1,0,1, 1,0,0,0,          0,0,          0,3);
        add(1,1, 9,'h1FF,      4, 1,0,1, 0,0,0,0,          1,'h104,      0,4);
        add(1,0, 0,0,          9, 0,0,1, 0,1,1,'h101,      0,0,          0,4);
        add(1,0, 0,0,          9, 0,0,1, 1,1,2,'h102,      0,0,          0,3);
        add(1,0, 0,0,          9, 0,0,1, 1,1,3,'h103,      0,0,          0,2);
        add(1,0, 0,0,          9, 0,0,1, 1,1,4,'h104,      0,0,          0,1);
        add(1,0, 0,0,          9, 0,0,1, 1,0,0,0,          0,0,          0,0);
        add(1,1, 7,'h11,       7, 1,0,1, 1,0,0,0,          0,0,          0,0);
        add(1,1, 7,'h22,       7, 1,0,1, 1,0,0,0,          1,'h11,       0,1);
        add(1,0, 0,0,          7, 1,0,1, 1,0,0,0,          1,'h22,       0,2);
        add(1,0, 0,0,          8, 1,0,1, 1,0,0,0,          0,0,          0,2);
        add(1,0, 0,0,          8, 0,1,1, 1,1,7,'h11,       0,0,          0,2);
        add(1,1, 3,'h33,       8, 0,0,1, 0,1,7,'h22,       0,0,          0,1);
        add(1,0, 0,0,          8, 0,0,1, 1,0,0,0,          0,0,          1,0);
        add(1,0, 0,0,          8, 0,0,1, 1,0,0,0,          0,0,          0,0);
        add(1,0, 0,0,          8, 0,1,1, 1,0,0,0,          0,0,          0,0);
        add(1,0, 0,0,          8, 0,0,1, 0,0,0,0,          0,0,          0,0);
        add(1,0, 0,0,          8, 0,0,1, 1,0,0,0,          0,0,          1,0);
        add(1,0, 0,0,          8, 0,0,1, 1,0,0,0,          0,0,          0,0);
        add(1,1,10,'hA,       10, 1,0,1, 1,0,0,0,          0,0,          0,0);
        add(1,1,11,'hB,       10, 1,0,1, 1,0,0,0,          1,'hA,        0,1);
        add(1,1,12,'hC,       10, 1,0,1, 1,0,0,0,          1,'hA,        0,2);
        add(0,1,13,'hD,       10, 1,1,1, 1,0,0,0,          1,'hA,        0,3);
        add(1,0, 0,0,         10, 0,0,1, 1,0,0,0,          0,0,          0,0);
        add(1,0, 0,0,         10, 0,0,1, 1,0,0,0,          0,0,          0,0);
        for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], i);

        // Sustained push+pop at DEPTH-1 occupancy, wrapping the pointers.
        mstep("wrap rst", 0, 0, '0, '0, '0, 0, 0);
        for (int i = 0; i < DEPTH - 1; i++)
            mstep("wrap fill", 1, 1, AW'(20 + i), DW'(32'h5000 + i), '0, 1, 0);
        for (int i = 0; i < 2 * DEPTH; i++)
            mstep("wrap pp", 1, 1, AW'(30 + i), DW'(32'h6000 + i), AW'(29 + i), 0, 0);
        for (int i = 0; i < DEPTH; i++)
            mstep("wrap drain", 1, 0, '0, '0, '0, 0, 0);

        for (int i = 0; i < 3000; i++)
            mstep("rand", $urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0,
                  AW'($urandom_range(0, 7)), DW'($urandom),
                  AW'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 19) == 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending-store entries (power of two, at least 2).
REQ-002 SHALL have parameter AW, default 6, data-memory word-address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 clr_n  in  1  reset, synchronous, active-low.
REQ-006 st_valid  in  1  MEM stage presents a committed store.
REQ-007 st_addr  in  AW  store word address.
REQ-008 st_data  in  DW  store data.
REQ-009 st_ready  out  1  buffer can accept a store this cycle.
REQ-010 ld_addr  in  AW  address of the load currently being read from data memory.
REQ-011 ld_hit  out  1  a buffered store matches ld_addr.
REQ-012 ld_data  out  DW  forwarded data when ld_hit is 1.
REQ-013 dm_busy  in  1  data-memory port is taken by a load this cycle.
REQ-014 dm_str, dm_sel  out  1 each  write strobe and select to data memory.
REQ-015 dm_addr  out  AW, dm_D  out  DW  write address and data to data memory.
REQ-016 sync_req  in  1  request a full drain (fence/halt).
REQ-017 sync_done  out  1  one-cycle pulse when a requested drain completes.
REQ-018 count  out  log2(DEPTH)+1  number of occupied entries.

Function
REQ-019 Circular FIFO; head/tail pointers SHALL wrap modulo DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-020 st_ready SHALL be !full; a push occurs when st_valid && st_ready, writing the tail entry at the clock edge.
REQ-021 st_valid while full SHALL be ignored, with no state change; upstream must hold the store.
REQ-022 A drain occurs when !empty && !dm_busy: dm_str=dm_sel=1, with dm_addr/dm_D taken combinationally from the head entry; the head SHALL be popped at the same edge at which the data memory writes.
REQ-023 When empty or dm_busy, dm_str and dm_sel SHALL be 0; dm_addr/dm_D are don't-care.
REQ-024 A simultaneous push and pop SHALL leave count unchanged; a push into an empty buffer SHALL NOT drain in the same cycle (minimum store-to-memory latency is 1 cycle).
REQ-025 Forwarding SHALL be combinational: ld_hit=1 iff some occupied entry has address==ld_addr; ld_data SHALL be the youngest matching entry. Otherwise ld_hit=0 and ld_data=0.
REQ-026 The entry being popped this cycle SHALL still participate in forwarding; the store being pushed this cycle SHALL NOT.
REQ-027 Sync FSM states: IDLE, DRAIN, DONE.
REQ-028 IDLE->DRAIN on sync_req.
REQ-029 In DRAIN, st_ready SHALL be forced to 0.
REQ-030 DRAIN->DONE when count==1 and a pop occurs, or when count==0.
REQ-031 DONE asserts sync_done for exactly one cycle, then returns to IDLE.
REQ-032 A sync_req arriving while in DRAIN or DONE SHALL be ignored.
REQ-033 count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-034 When clr_n=0 at a rising edge: pointers=0, count=0, FSM=IDLE, all entries invalid; in the following cycle st_ready=1, ld_hit=0, ld_data=0, dm_str=dm_sel=0, sync_done=0.
REQ-035 A reset mid-drain or mid-sync SHALL discard all pending stores without writing memory; clr_n has priority over all other inputs.

Verification
REQ-036 Reset, then push addr 5/data 0xAAAA0001 with dm_busy=0 -> next cycle dm_str=1, dm_addr=5, dm_D=0xAAAA0001; after that edge count=0.
REQ-037 dm_busy=1, push 4 stores to addrs 1,2,3,4 -> count=4, st_ready=0; a 5th st_valid is dropped; drop dm_busy -> 4 writes in FIFO order over 4 cycles.
REQ-038 dm_busy=1, push addr 7 data 0x11 then addr 7 data 0x22; ld_addr=7 -> ld_hit=1, ld_data=0x22; ld_addr=8 -> ld_hit=0, ld_data=0.
REQ-039 count=2, pulse sync_req -> st_ready=0 until done; after 2 drain cycles sync_done pulses 1 cycle; FSM returns to IDLE and st_ready=1.
REQ-040 count=3 and dm_busy=1, assert clr_n=0 for one edge -> count=0, ld_hit=0, no dm_str issued afterwards.
REQ-041 count=DEPTH-1 with simultaneous push and pop, repeated for 2*DEPTH cycles -> count stays constant; pointers wrap with no lost or duplicated writes.
